// File: rtl/instr_slot_feeder.sv
// Deals a serial instruction stream round-robin into two FWFT queues; slots are presented only once a batch is loaded.
// Latency: a word pushed into an empty queue is at the head one cycle later, and on en_outN only in RUN.
// Backpressure: in_ready drops when the target queue is full, or in RUN once the batch's last word has been taken.
module instr_slot_feeder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              in_last,
    output logic              en_out0,
    output logic [31:0]       instr_out0,
    input  logic              en_ack0,
    output logic              en_out1,
    output logic [31:0]       instr_out1,
    input  logic              en_ack1,
    output logic              busy,
    output logic [ADDR_W:0]   occ0,
    output logic [ADDR_W:0]   occ1
);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic                tgl_q, tgl_d;
    logic                last_seen_q, last_seen_d;
    logic [ADDR_W:0]     occ0_q, occ0_d, occ1_q, occ1_d;
    logic [ADDR_W-1:0]   wr0_q, wr0_d, rd0_q, rd0_d;
    logic [ADDR_W-1:0]   wr1_q, wr1_d, rd1_q, rd1_d;
    logic [31:0]         mem0_q [DEPTH];
    logic [31:0]         mem1_q [DEPTH];

    logic run, both_empty, full0, full1, tgt, accept;
    logic push0, push1, pop0, pop1;

    always_comb begin
        run        = (state_q == ST_RUN);
        both_empty = (occ0_q == '0) && (occ1_q == '0);
        full0      = (occ0_q == DEPTH_L);
        full1      = (occ1_q == DEPTH_L);
        // The dispatcher restarts at slot 0 whenever both slots go idle, so we must too.
        tgt        = both_empty ? 1'b0 : tgl_q;
        in_ready   = ~(tgt ? full1 : full0) & ~(run & last_seen_q);
        accept     = in_valid & in_ready;
        push0      = accept & ~tgt;
        push1      = accept & tgt;
        en_out0    = (occ0_q != '0) & run;
        en_out1    = (occ1_q != '0) & run;
        pop0       = en_out0 & en_ack0;
        pop1       = en_out1 & en_ack1;
        instr_out0 = (occ0_q != '0) ? mem0_q[rd0_q] : 32'h0;
        instr_out1 = (occ1_q != '0) ? mem1_q[rd1_q] : 32'h0;
        busy       = run;
        occ0       = occ0_q;
        occ1       = occ1_q;
    end

    always_comb begin
        wr0_d  = wr0_q + ADDR_W'(push0);
        wr1_d  = wr1_q + ADDR_W'(push1);
        rd0_d  = rd0_q + ADDR_W'(pop0);
        rd1_d  = rd1_q + ADDR_W'(pop1);
        occ0_d = occ0_q;
        occ1_d = occ1_q;
        case ({push0, pop0})
            2'b10:   occ0_d = occ0_q + ONE_L;
            2'b01:   occ0_d = occ0_q - ONE_L;
            default: occ0_d = occ0_q;
        endcase
        case ({push1, pop1})
            2'b10:   occ1_d = occ1_q + ONE_L;
            2'b01:   occ1_d = occ1_q - ONE_L;
            default: occ1_d = occ1_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tgl_d       = tgl_q;
        last_seen_d = last_seen_q;
        if (accept) begin
            tgl_d = ~tgt;
        end
        case (state_q)
            ST_LOAD: begin
                if (accept && in_last) begin
                    state_d     = ST_RUN;
                    last_seen_d = 1'b1;
                end else if (full0 && full1) begin
                    // Program longer than both queues: release it and keep streaming.
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && in_last) begin
                    last_seen_d = 1'b1;
                end
                if (both_empty && last_seen_q) begin
                    state_d     = ST_LOAD;
                    tgl_d       = 1'b0;
                    last_seen_d = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            tgl_q       <= 1'b0;
            last_seen_q <= 1'b0;
            occ0_q      <= '0;
            occ1_q      <= '0;
            wr0_q       <= '0;
            wr1_q       <= '0;
            rd0_q       <= '0;
            rd1_q       <= '0;
        end else begin
            state_q     <= state_d;
            tgl_q       <= tgl_d;
            last_seen_q <= last_seen_d;
            occ0_q      <= occ0_d;
            occ1_q      <= occ1_d;
            wr0_q       <= wr0_d;
            wr1_q       <= wr1_d;
            rd0_q       <= rd0_d;
            rd1_q       <= rd1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push0) begin
            mem0_q[wr0_q] <= in_instr;
        end
        if (push1) begin
            mem1_q[wr1_q] <= in_instr;
        end
    end

    a_occ0_bound: assert property (@(posedge clk) disable iff (rst) occ0_q <= DEPTH_L);
    a_occ1_bound: assert property (@(posedge clk) disable iff (rst) occ1_q <= DEPTH_L);
    a_no_ovf:     assert property (@(posedge clk) disable iff (rst) !(push0 && full0) && !(push1 && full1));
    a_no_udf:     assert property (@(posedge clk) disable iff (rst) !(pop0 && occ0_q == '0) && !(pop1 && occ1_q == '0));

endmodule

// File: tb/tb_instr_slot_feeder.sv
// Directed bench for instr_slot_feeder: batch gating, round-robin dealing, drain, forced release, reset.
// Latency: outputs sampled 1ns after each rising edge, inputs changed right after sampling.
// Backpressure: dispatcher acks driven directly; in_ready checked against hand-computed values.
module tb_instr_slot_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_last;
    logic        en_out0, en_out1;
    logic [31:0] instr_out0, instr_out1;
    logic        en_ack0, en_ack1;
    logic        busy;
    logic [4:0]  occ0, occ1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instr_slot_feeder #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_last    (in_last),
        .en_out0    (en_out0),
        .instr_out0 (instr_out0),
        .en_ack0    (en_ack0),
        .en_out1    (en_out1),
        .instr_out1 (instr_out1),
        .en_ack1    (en_ack1),
        .busy       (busy),
        .occ0       (occ0),
        .occ1       (occ1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_last = 1'b0;
        en_ack0 = 1'b0; en_ack1 = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_occ0", 32'(occ0), 0);
        chk("rst_occ1", 32'(occ1), 0);
        chk("rst_en0", 32'(en_out0), 0);
        chk("rst_en1", 32'(en_out1), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdy", 32'(in_ready), 1);
        chk("rst_instr0", instr_out0, 0);

        // Batch A,B,C(last): gated in LOAD until C accepted
        in_valid = 1'b1; in_instr = 32'hA; in_last = 1'b0;
        step();
        chk("t1_occ0_a", 32'(occ0), 1);
        chk("t1_en0_load", 32'(en_out0), 0);
        chk("t1_busy_load", 32'(busy), 0);
        in_instr = 32'hB;
        step();
        chk("t1_occ1_b", 32'(occ1), 1);
        chk("t1_en1_load", 32'(en_out1), 0);
        in_instr = 32'hC; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("t1_busy", 32'(busy), 1);
        chk("t1_en0", 32'(en_out0), 1);
        chk("t1_en1", 32'(en_out1), 1);
        chk("t1_head0", instr_out0, 32'hA);
        chk("t1_head1", instr_out1, 32'hB);
        chk("t1_occ0", 32'(occ0), 2);
        chk("t1_occ1", 32'(occ1), 1);
        chk("t1_rdy_blocked", 32'(in_ready), 0);

        // Drain with both acks held
        en_ack0 = 1'b1; en_ack1 = 1'b1;
        step();
        chk("t2_head0_c", instr_out0, 32'hC);
        chk("t2_occ0", 32'(occ0), 1);
        chk("t2_occ1", 32'(occ1), 0);
        chk("t2_en1_idle", 32'(en_out1), 0);
        step();
        chk("t2_occ0_empty", 32'(occ0), 0);
        chk("t2_busy_still", 32'(busy), 1);
        chk("t2_en0_empty", 32'(en_out0), 0);
        en_ack0 = 1'b0; en_ack1 = 1'b0;
        step();
        chk("t2_busy_load", 32'(busy), 0);
        chk("t2_rdy", 32'(in_ready), 1);

        // Stream 32 words without last: forced release when both full
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_instr = 32'h100 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        chk("t3_occ0_full", 32'(occ0), 16);
        chk("t3_occ1_full", 32'(occ1), 16);
        chk("t3_rdy_full", 32'(in_ready), 0);
        chk("t3_busy_pre", 32'(busy), 0);
        chk("t3_en0_pre", 32'(en_out0), 0);
        step();
        chk("t3_busy", 32'(busy), 1);
        chk("t3_head0", instr_out0, 32'h100);
        chk("t3_head1", instr_out1, 32'h101);
        en_ack1 = 1'b1;
        step();
        en_ack1 = 1'b0;
        chk("t3_occ1_pop", 32'(occ1), 15);
        chk("t3_rdy_q1_open", 32'(in_ready), 0);
        en_ack0 = 1'b1;
        step();
        en_ack0 = 1'b0;
        chk("t3_occ0_pop", 32'(occ0), 15);
        chk("t3_rdy_q0_open", 32'(in_ready), 1);
        chk("t3_head0_next", instr_out0, 32'h102);
        chk("t3_head1_next", instr_out1, 32'h103);

        // Underrun in RUN with tgl=1: next word falls back to queue0
        in_valid = 1'b1; in_instr = 32'h200;
        step();
        in_valid = 1'b0;
        chk("t4_occ0", 32'(occ0), 16);
        en_ack0 = 1'b1; en_ack1 = 1'b1;
        for (int i = 0; i < 16; i++) step();
        en_ack0 = 1'b0; en_ack1 = 1'b0;
        chk("t4_occ0_drained", 32'(occ0), 0);
        chk("t4_occ1_drained", 32'(occ1), 0);
        chk("t4_busy_underrun", 32'(busy), 1);
        in_valid = 1'b1; in_instr = 32'h300;
        step();
        in_valid = 1'b0;
        chk("t4_occ0_fallback", 32'(occ0), 1);
        chk("t4_occ1_fallback", 32'(occ1), 0);
        chk("t4_head0", instr_out0, 32'h300);
        chk("t4_en0", 32'(en_out0), 1);

        // Last in RUN blocks input until both queues empty
        in_valid = 1'b1; in_instr = 32'h301; in_last = 1'b1;
        step();
        chk("t5_occ1", 32'(occ1), 1);
        chk("t5_rdy_blocked", 32'(in_ready), 0);
        in_instr = 32'h400; in_last = 1'b0;
        step();
        chk("t5_occ0_hold", 32'(occ0), 1);
        chk("t5_occ1_hold", 32'(occ1), 1);
        en_ack0 = 1'b1; en_ack1 = 1'b1;
        step();
        en_ack0 = 1'b0; en_ack1 = 1'b0;
        chk("t5_occ0_empty", 32'(occ0), 0);
        chk("t5_rdy_still", 32'(in_ready), 0);
        chk("t5_busy_still", 32'(busy), 1);
        step();
        chk("t5_busy_load", 32'(busy), 0);
        chk("t5_rdy_open", 32'(in_ready), 1);
        chk("t5_occ0_zero", 32'(occ0), 0);
        step();
        in_valid = 1'b0;
        chk("t5_occ0_new", 32'(occ0), 1);
        chk("t5_head0_new", instr_out0, 32'h400);
        chk("t5_en0_load", 32'(en_out0), 0);

        // Reset mid-batch with occ0=5, occ1=4
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_instr = 32'h500 + 32'(i); in_last = (i == 7);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("t6_occ0", 32'(occ0), 5);
        chk("t6_occ1", 32'(occ1), 4);
        chk("t6_busy", 32'(busy), 1);
        rst = 1'b1; en_ack0 = 1'b1; en_ack1 = 1'b1;
        step();
        chk("t6_occ0_rst", 32'(occ0), 0);
        chk("t6_occ1_rst", 32'(occ1), 0);
        chk("t6_en0_rst", 32'(en_out0), 0);
        chk("t6_en1_rst", 32'(en_out1), 0);
        chk("t6_busy_rst", 32'(busy), 0);
        chk("t6_rdy_rst", 32'(in_ready), 1);
        rst = 1'b0;
        step();
        chk("t6_en0_after", 32'(en_out0), 0);
        chk("t6_en1_after", 32'(en_out1), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
